// File: rtl/clock_tracker_pkg.sv
// Shared types and defaults for the slow-clock edge tracker.
// State encodings are plain localparams so legacy code can compare against them directly.
package clock_tracker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle     = 2'd0;
  localparam state_t StAcqFirst = 2'd1;
  localparam state_t StAcquire  = 2'd2;
  localparam state_t StLocked   = 2'd3;

  localparam int unsigned DefaultTolerance = 2;
  localparam int unsigned DefaultLockCount = 4;

endpackage

// File: rtl/clock_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module clock_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    prev_d = level;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/clock_edge_tracker.sv
// Tracks an asynchronous slow clock: regenerates rise/fall enables in CLK, measures the
// rise-to-rise period, and reports lock (stable period) and loss-of-clock status.
module clock_edge_tracker
  import clock_tracker_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT     = 40000000,
  parameter int unsigned LOCK_COUNT  = DefaultLockCount,
  parameter int unsigned TOLERANCE   = DefaultTolerance
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLOCK_IN,
  output logic                 CE_RISE,
  output logic                 CE_FALL,
  output logic [CNT_WIDTH-1:0] PERIOD,
  output logic                 PERIOD_VALID,
  output logic                 LOCKED,
  output logic                 LOST
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1) + 1;

  localparam logic [CNT_WIDTH-1:0]     TimeoutM1  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [MatchW-1:0]        LockCountM = MatchW'(LOCK_COUNT);
  localparam logic signed [CNT_WIDTH:0] ToleranceS = $signed((CNT_WIDTH + 1)'(TOLERANCE));

  logic rise, fall;

  clock_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .async_i (CLOCK_IN),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [CNT_WIDTH-1:0]  ref_period_q, ref_period_d;
  logic [MatchW-1:0]     match_q, match_d;
  logic                  ce_rise_q, ce_rise_d;
  logic                  ce_fall_q, ce_fall_d;
  logic                  valid_q, valid_d;
  logic                  locked_q, locked_d;
  logic                  lost_q, lost_d;

  logic [CNT_WIDTH-1:0]  meas;
  logic [MatchW-1:0]     match_inc;
  logic signed [CNT_WIDTH:0] diff, abs_diff;
  logic                  in_tol;
  logic                  cnt_sat;

  always_comb begin
    meas      = cnt_q + 1'b1;
    match_inc = match_q + 1'b1;
    // One extra bit keeps the difference of two unsigned counts from wrapping.
    diff      = $signed({1'b0, meas}) - $signed({1'b0, ref_period_q});
    abs_diff  = diff[CNT_WIDTH] ? -diff : diff;
    in_tol    = (abs_diff <= ToleranceS);
    cnt_sat   = (cnt_q == TimeoutM1);
  end

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    ref_period_d = ref_period_q;
    match_d      = match_q;
    valid_d      = valid_q;
    lost_d       = lost_q;
    ce_rise_d    = rise;
    ce_fall_d    = fall;
    cnt_d        = rise ? '0 : (cnt_sat ? cnt_q : cnt_q + 1'b1);

    if (rise) begin
      // A rise always beats a coincident timeout.
      lost_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          state_d = StAcqFirst;
        end
        StAcqFirst: begin
          period_d     = meas;
          valid_d      = 1'b1;
          ref_period_d = meas;
          match_d      = MatchW'(1);
          state_d      = (LOCK_COUNT <= 1) ? StLocked : StAcquire;
        end
        StAcquire: begin
          period_d = meas;
          if (in_tol) begin
            match_d = match_inc;
            if (match_inc >= LockCountM) state_d = StLocked;
          end else begin
            ref_period_d = meas;
            match_d      = MatchW'(1);
          end
        end
        StLocked: begin
          period_d = meas;
          if (!in_tol) begin
            ref_period_d = meas;
            match_d      = MatchW'(1);
            state_d      = StAcquire;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && cnt_sat) begin
      state_d = StIdle;
      lost_d  = 1'b1;
      valid_d = 1'b0;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      period_q     <= '0;
      ref_period_q <= '0;
      match_q      <= '0;
      ce_rise_q    <= 1'b0;
      ce_fall_q    <= 1'b0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      ref_period_q <= ref_period_d;
      match_q      <= match_d;
      ce_rise_q    <= ce_rise_d;
      ce_fall_q    <= ce_fall_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
    end
  end

  assign CE_RISE      = ce_rise_q;
  assign CE_FALL      = ce_fall_q;
  assign PERIOD       = period_q;
  assign PERIOD_VALID = valid_q;
  assign LOCKED       = locked_q;
  assign LOST         = lost_q;

endmodule

// File: tb/tb_clock_edge_tracker.sv
// Directed bench for clock_edge_tracker: CLOCK_IN is driven on CLK falling edges so every
// input edge lands a known number of CLK edges before the tracker sees it.
module tb_clock_edge_tracker;

  logic        CLK;
  logic        RESET;
  logic        CLOCK_IN;
  logic        CE_RISE;
  logic        CE_FALL;
  logic [31:0] PERIOD;
  logic        PERIOD_VALID;
  logic        LOCKED;
  logic        LOST;

  clock_edge_tracker #(
    .SYNC_STAGES (2),
    .CNT_WIDTH   (32),
    .TIMEOUT     (100),
    .LOCK_COUNT  (4),
    .TOLERANCE   (2)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CLOCK_IN     (CLOCK_IN),
    .CE_RISE      (CE_RISE),
    .CE_FALL      (CE_FALL),
    .PERIOD       (PERIOD),
    .PERIOD_VALID (PERIOD_VALID),
    .LOCKED       (LOCKED),
    .LOST         (LOST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int since       = 0;  // CLK cycles elapsed since the last CLOCK_IN rise was driven

  // {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD}
  logic [36:0] obs, exp;

  // Called on a falling CLK edge. Finishes the current input period of P cycles, drives the
  // next rise, and returns on the falling edge just after CE_RISE is expected to be high.
  task automatic next_rise(input int p);
    for (int i = since; i < p; i++) begin
      if (i == p / 2) CLOCK_IN = 1'b0;
      @(negedge CLK);
    end
    CLOCK_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    since = 3;
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    CLOCK_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_state got %h exp %h", obs, exp);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_ce_timing();
    logic [1:0] ce_obs, ce_exp;
    @(negedge CLK);
    CLOCK_IN = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK);
      #1;
      ce_obs = {CE_RISE, CE_FALL};
      ce_exp = {(k == 3), 1'b0};
      vectors++;
      if (ce_obs !== ce_exp) begin
        miscompares++;
        $display("FAIL ce_rise_edge%0d got %b exp %b", k, ce_obs, ce_exp);
      end
    end
    @(negedge CLK);
    CLOCK_IN = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK);
      #1;
      ce_obs = {CE_RISE, CE_FALL};
      ce_exp = {1'b0, (k == 3)};
      vectors++;
      if (ce_obs !== ce_exp) begin
        miscompares++;
        $display("FAIL ce_fall_edge%0d got %b exp %b", k, ce_obs, ce_exp);
      end
    end
    @(negedge CLK);
    since = 8;
  endtask

  task automatic test_lock();
    bit lk [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      next_rise(10);
      obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, lk[i], 32'd10};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL lock_rise%0d got %h exp %h", i + 2, obs, exp);
      end
    end
  endtask

  task automatic test_tolerance();
    int per [7] = '{9, 11, 12, 13, 12, 14, 15};
    bit lk  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      next_rise(per[i]);
      obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, lk[i], 32'(per[i])};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL tolerance[%0d] got %h exp %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_period_jump();
    int per [8] = '{10, 10, 10, 10, 20, 20, 20, 20};
    bit lk  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      next_rise(per[i]);
      obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, lk[i], 32'(per[i])};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL jump[%0d] got %h exp %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    bit lk [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      next_rise(10);
      obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, lk[i], 32'd10};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL relock10[%0d] got %h exp %h", i, obs, exp);
      end
    end
    // CLOCK_IN now stays high; the last rise registered one half cycle ago.
    repeat (99) @(posedge CLK);
    #1;
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd10};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL timeout_minus1 got %h exp %h", obs, exp);
    end
    @(posedge CLK);
    #1;
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL timeout_lost got %h exp %h", obs, exp);
    end
    @(negedge CLK);
    since = 0;
    next_rise(10);
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd10};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL restart_first got %h exp %h", obs, exp);
    end
    next_rise(10);
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL restart_second got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_rise_at_timeout();
    // Rise lands on the cycle where the counter sits at TIMEOUT-1.
    next_rise(100);
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd100};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL rise_at_timeout got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_reset_midlock();
    bit lk  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit vl2 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit lk2 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int pr2 [5] = '{0, 10, 10, 10, 10};
    for (int i = 0; i < 4; i++) begin
      next_rise(10);
      obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
      exp = {1'b1, 1'b0, 1'b0, 1'b1, lk[i], 32'd10};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL prelock[%0d] got %h exp %h", i, obs, exp);
      end
    end
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_reset got %h exp %h", obs, exp);
    end
    CLOCK_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    since = 0;
    for (int i = 0; i < 5; i++) begin
      next_rise(10);
      obs = {CE_RISE, CE_FALL, LOST, PERIOD_VALID, LOCKED, PERIOD};
      exp = {1'b1, 1'b0, 1'b0, vl2[i], lk2[i], 32'(pr2[i])};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reacquire_rise%0d got %h exp %h", i + 1, obs, exp);
      end
    end
  endtask

  initial begin
    RESET    = 1'b1;
    CLOCK_IN = 1'b0;
    test_reset();
    test_ce_timing();
    test_lock();
    test_tolerance();
    test_period_jump();
    test_timeout();
    test_rise_at_timeout();
    test_reset_midlock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_edge_tracker.md
Name: clock_edge_tracker

Overview:
Receive-side companion to the team's clock divider. It takes an asynchronous slow clock (for example a divided CLOCK output from another board or domain) and synchronizes it into CLK. It regenerates one-cycle rise and fall clock enables and measures the input period in CLK cycles. It also reports lock and loss-of-clock status, and is used wherever logic must run in step with an external slow clock without using a BUFG.

Parameters:
SYNC_STAGES, 2, number of synchronizer flip-flops on CLOCK_IN (min 2)
CNT_WIDTH, 32, width of period counter and PERIOD output
TIMEOUT, 40000000, CLK cycles without a rising edge before the input is declared lost (must fit CNT_WIDTH)
LOCK_COUNT, 4, consecutive in-tolerance periods required for lock
TOLERANCE, 2, allowed absolute deviation (CLK cycles) from reference period

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
CLOCK_IN  input  1  asynchronous slow clock to track
CE_RISE  output  1  one-cycle pulse per detected rising edge of CLOCK_IN
CE_FALL  output  1  one-cycle pulse per detected falling edge of CLOCK_IN
PERIOD  output  CNT_WIDTH  last measured rise-to-rise period in CLK cycles
PERIOD_VALID  output  1  PERIOD holds a valid measurement
LOCKED  output  1  input period stable within TOLERANCE
LOST  output  1  sticky timeout flag, cleared by next rising edge

Behaviour:
- Reset. RESET is asynchronous, active-high, clock CLK. The synchronizer, edge history, counter, PERIOD, ref and match are all cleared to 0, and the state is IDLE. All outputs are 0 at reset.
- Synchronizer. A SYNC_STAGES flop chain feeds a prev register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - CE_RISE/CE_FALL are registered copies of rise/fall. Each is high for exactly 1 cycle, SYNC_STAGES+1 CLK edges after the first edge that samples the new level.
- Counter cnt.
  - On rise: cleared to 0.
  - Otherwise: increments, saturating at TIMEOUT-1.
  - Measured period p = cnt+1, evaluated on rise. An input of period P CLK cycles gives p = P.
- FSM states:
  - IDLE: no edge seen. On rise -> ACQUIRE_FIRST.
  - ACQUIRE_FIRST: one rise seen. On rise: PERIOD<=p, PERIOD_VALID<=1, ref<=p, match<=1 -> ACQUIRE. If LOCK_COUNT==1 -> LOCKED.
  - ACQUIRE: on rise, PERIOD<=p.
    - If |p-ref|<=TOLERANCE: match++. When match reaches LOCK_COUNT -> LOCKED.
    - Else: ref<=p, match<=1, stay.
  - LOCKED: LOCKED=1. On rise, PERIOD<=p.
    - If out of tolerance: ref<=p, match<=1 -> ACQUIRE (LOCKED drops the next cycle).
    - ref is not updated while in tolerance.
- Timeout. In any state other than IDLE, cnt==TIMEOUT-1 with no rise triggers:
  - state -> IDLE;
  - LOST<=1, LOCKED<=0, PERIOD_VALID<=0;
  - PERIOD holds its last value.
- LOST clears on the cycle the next rise is detected.
- Simultaneous rise and timeout in the same cycle: the rise wins and no timeout is declared.
- Outputs are registered. LOCKED/PERIOD/PERIOD_VALID update in the same cycle as CE_RISE.
- Subtraction for the tolerance check uses CNT_WIDTH+1 signed arithmetic, so there is no wrap.
- A glitch shorter than one CLK period may be missed. This is acceptable and not flagged.

Decomposition:
- Shared package clock_tracker_pkg:
  - state enum (IDLE, ACQUIRE_FIRST, ACQUIRE, LOCKED);
  - default constants for TOLERANCE/LOCK_COUNT.
- One sub-module, clock_sync_edge: SYNC_STAGES synchronizer plus prev register, outputting rise/fall. It is reusable for other async strobes.

Test Plan:
- Period 10 input, LOCK_COUNT=4 -> PERIOD=10 from the 2nd rise, PERIOD_VALID=1 at the 2nd rise, LOCKED=1 at the 5th rise. CE_RISE/CE_FALL are each 1 cycle wide, 3 edges after the input edge.
- Locked at 10, periods alternate 9/11/12 -> LOCKED stays 1. A period of 13 -> LOCKED=0, ref=13, match=1, and relock after 3 more periods within 11..15.
- Period jumps 10->20 -> unlock on the first 20, PERIOD=20, LOCKED again 3 rises later.
- TIMEOUT=100, input stopped high while locked -> 100 cycles after the last rise: LOST=1, LOCKED=0, PERIOD_VALID=0, PERIOD=10 held. Input restarts -> LOST clears at the first CE_RISE, state ACQUIRE_FIRST.
- Rise detected exactly on the cnt==TIMEOUT-1 cycle -> no LOST, PERIOD=TIMEOUT.
- RESET asserted mid-lock, asynchronously between CLK edges -> all outputs 0 immediately. After release, a full reacquisition is needed: LOCKED only after LOCK_COUNT+1 rises.
